// File: rtl/conware_row_sequencer_pkg.sv
// conware_pkg: shared types and constants for the Conway row sequencer slice.
//   seq_state_t   : sequencer FSM state encoding (3-bit)
//   ROW_W         : width of the row index carried with each window
//   CONWARE_WIDTH : default cells per row, shared with the row converter
package conware_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE = 3'd0,
    SEQ_FILL = 3'd1,
    SEQ_LOAD = 3'd2,
    SEQ_EMIT = 3'd3,
    SEQ_LAST = 3'd4
  } seq_state_t;

  localparam int ROW_W         = 8;
  localparam int CONWARE_WIDTH = 4;

endpackage

// File: rtl/conware_row_sequencer_if.sv
// conware_row_sequencer_if: row stream from the converter plus the window
// command towards the compute engine, bundled as one handshake bus.
//   in_data/in_valid/in_ready          : row stream (valid/ready)
//   win_top/win_mid/win_bot/win_row    : 3-row window and index of win_mid
//   win_valid/win_ready                : window command handshake
// Modports: slave = sequencer side, master = environment side.
interface conware_row_sequencer_if
  import conware_pkg::*;
#(
  parameter int WIDTH = CONWARE_WIDTH
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] win_top;
  logic [WIDTH-1:0] win_mid;
  logic [WIDTH-1:0] win_bot;
  logic [ROW_W-1:0] win_row;
  logic             win_valid;
  logic             win_ready;

  modport slave (
    input  in_data, in_valid, win_ready,
    output in_ready, win_top, win_mid, win_bot, win_row, win_valid
  );

  modport master (
    output in_data, in_valid, win_ready,
    input  in_ready, win_top, win_mid, win_bot, win_row, win_valid
  );

endinterface

// File: rtl/conware_row_sequencer_window.sv
// conware_row_window: the three-row sliding window (prev/cur/nxt).
//   clk, rstn   : clock, asynchronous active-low reset
//   load_first  : row 0 accepted -> cur <= row_in, prev <= 0
//   load_next   : following row accepted -> nxt <= row_in
//   shift       : window accepted -> prev <= cur, cur <= nxt
//   pad_bot     : last row of the frame, bottom row is outside the frame
//   row_in      : row bits from the converter
//   top/mid/bot : window rows presented to the compute engine
module conware_row_window
  import conware_pkg::*;
#(
  parameter int WIDTH = CONWARE_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_first,
  input  logic             load_next,
  input  logic             shift,
  input  logic             pad_bot,
  input  logic [WIDTH-1:0] row_in,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] mid,
  output logic [WIDTH-1:0] bot
);

  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] cur_q;
  logic [WIDTH-1:0] nxt_q;

  // The FSM guarantees at most one of the three strobes per cycle; the
  // priority order only matters for robustness. Clearing prev on the first
  // row provides the zero padding above row 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prev_q <= '0;
      cur_q  <= '0;
      nxt_q  <= '0;
    end else if (load_first) begin
      prev_q <= '0;
      cur_q  <= row_in;
    end else if (load_next) begin
      nxt_q <= row_in;
    end else if (shift) begin
      prev_q <= cur_q;
      cur_q  <= nxt_q;
    end
  end

  assign top = prev_q;
  assign mid = cur_q;
  // nxt still holds the previous row during the last window, so mask it.
  assign bot = pad_bot ? '0 : nxt_q;

endmodule

// File: rtl/conware_row_sequencer.sv
// conware_row_sequencer: frame-level controller between the stream-to-row
// converter and the Conway next-state engine. Pulls rows one at a time,
// keeps a zero-padded 3-row window and issues one window per row.
//   clk, rstn     : clock, asynchronous active-low reset
//   enable        : run request, sampled in IDLE and at frame end
//   bus (slave)   : row stream in, window command out
//   frame_start   : one-cycle pulse after row 0 is accepted
//   frame_done    : one-cycle pulse after the last window is accepted
//   gen_count     : completed frames, wraps modulo 2^GEN_W
//   busy          : high in every state except IDLE
// Optional build macro CONWARE_SEQ_STALL_CNT_EN adds in_stall_cnt and
// out_stall_cnt (saturating, cleared when row 0 of a frame is accepted).
// HEIGHT must lie in 2..255.
module conware_row_sequencer
  import conware_pkg::*;
#(
  parameter int WIDTH  = CONWARE_WIDTH,
  parameter int HEIGHT = 4,
  parameter int GEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  conware_row_sequencer_if.slave bus,
  output logic                  frame_start,
  output logic                  frame_done,
  output logic [GEN_W-1:0]      gen_count,
  output logic                  busy
`ifdef CONWARE_SEQ_STALL_CNT_EN
  ,
  output logic [31:0]           in_stall_cnt,
  output logic [31:0]           out_stall_cnt
`endif
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  seq_state_t       state_q;
  seq_state_t       state_d;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] row_inc;
  logic [GEN_W-1:0] gen_q;
  logic             frame_start_q;
  logic             frame_done_q;

  logic             in_ready_d;
  logic             win_valid_d;
  logic             busy_d;

  logic             fill_accept;
  logic             load_accept;
  logic             emit_accept;
  logic             last_accept;

  logic [WIDTH-1:0] top_w;
  logic [WIDTH-1:0] mid_w;
  logic [WIDTH-1:0] bot_w;

  assign row_inc = row_q + ROW_W'(1);

  assign fill_accept = (state_q == SEQ_FILL) && bus.in_valid;
  assign load_accept = (state_q == SEQ_LOAD) && bus.in_valid;
  assign emit_accept = (state_q == SEQ_EMIT) && bus.win_ready;
  assign last_accept = (state_q == SEQ_LAST) && bus.win_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= SEQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake strobes are pure state decodes, so in_ready and win_valid
  // can never overlap and nothing combinational runs from in_valid or
  // win_ready to the outputs.
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    win_valid_d = 1'b0;
    busy_d      = 1'b1;
    case (state_q)
      SEQ_IDLE: begin
        busy_d = 1'b0;
        if (enable) state_d = SEQ_FILL;
      end
      SEQ_FILL: begin
        in_ready_d = 1'b1;
        if (bus.in_valid) state_d = SEQ_LOAD;
      end
      SEQ_LOAD: begin
        in_ready_d = 1'b1;
        if (bus.in_valid) state_d = SEQ_EMIT;
      end
      SEQ_EMIT: begin
        win_valid_d = 1'b1;
        if (bus.win_ready) state_d = (row_inc == LAST_ROW) ? SEQ_LAST : SEQ_LOAD;
      end
      SEQ_LAST: begin
        win_valid_d = 1'b1;
        if (bus.win_ready) state_d = enable ? SEQ_FILL : SEQ_IDLE;
      end
      default: begin
        state_d = SEQ_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Row index of win_mid; once it reaches HEIGHT-1 the FSM sits in LAST,
  // so the same register serves both window states.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q         <= '0;
      gen_q         <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      frame_start_q <= fill_accept;
      frame_done_q  <= last_accept;
      if (fill_accept) begin
        row_q <= '0;
      end else if (emit_accept) begin
        row_q <= row_inc;
      end
      if (last_accept) begin
        gen_q <= gen_q + GEN_W'(1);
      end
    end
  end

  conware_row_window #(
    .WIDTH(WIDTH)
  ) u_window (
    .clk        (clk),
    .rstn       (rstn),
    .load_first (fill_accept),
    .load_next  (load_accept),
    .shift      (emit_accept),
    .pad_bot    (state_q == SEQ_LAST),
    .row_in     (bus.in_data),
    .top        (top_w),
    .mid        (mid_w),
    .bot        (bot_w)
  );

  assign bus.in_ready  = in_ready_d;
  assign bus.win_valid = win_valid_d;
  assign bus.win_top   = top_w;
  assign bus.win_mid   = mid_w;
  assign bus.win_bot   = bot_w;
  assign bus.win_row   = row_q;

  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign gen_count   = gen_q;
  assign busy        = busy_d;

`ifdef CONWARE_SEQ_STALL_CNT_EN
  logic [31:0] in_stall_q;
  logic [31:0] out_stall_q;

  // Cleared on the edge that accepts row 0, so waiting in FILL before a
  // frame begins never shows up in the new frame's count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_stall_q  <= '0;
      out_stall_q <= '0;
    end else if (fill_accept) begin
      in_stall_q  <= '0;
      out_stall_q <= '0;
    end else begin
      if (in_ready_d && !bus.in_valid && !(&in_stall_q)) begin
        in_stall_q <= in_stall_q + 32'd1;
      end
      if (win_valid_d && !bus.win_ready && !(&out_stall_q)) begin
        out_stall_q <= out_stall_q + 32'd1;
      end
    end
  end

  assign in_stall_cnt  = in_stall_q;
  assign out_stall_cnt = out_stall_q;
`endif

endmodule

// File: tb/tb_conware_row_sequencer.sv
// tb_conware_row_sequencer: self-checking bench for conware_row_sequencer.
// Two instances share clock and reset: HEIGHT=4/GEN_W=16 and HEIGHT=2/GEN_W=2.
// Row data, input gaps and output stalls are randomized; expected windows
// come from the frame's row list with zero padding above/below the frame.
// With CONWARE_SEQ_STALL_CNT_EN defined the stall counters are checked too.
module tb_conware_row_sequencer;
  import conware_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  bit         sel;
  logic       drv_en;
  logic       drv_valid;
  logic       drv_ready;
  logic [3:0] drv_data;

  int check_count = 0;
  int pass_count  = 0;

  int cfg_in_gap, cfg_out_stall, cfg_out_row, cfg_drop_win, cfg_reset_win;
  bit cfg_in_rand, cfg_out_rand;

  logic [3:0] frame_rows[$];
  int gen_exp4 = 0;
  int gen_exp2 = 0;

  always #5 clk = ~clk;

  conware_row_sequencer_if #(.WIDTH(4)) bus4 ();
  conware_row_sequencer_if #(.WIDTH(4)) bus2 ();

  logic        en4, en2, fs4, fs2, fd4, fd2, busy4, busy2;
  logic [15:0] gen4;
  logic [1:0]  gen2;

  assign en4            = drv_en & ~sel;
  assign en2            = drv_en & sel;
  assign bus4.in_data   = drv_data;
  assign bus4.in_valid  = drv_valid & ~sel;
  assign bus4.win_ready = drv_ready;
  assign bus2.in_data   = drv_data;
  assign bus2.in_valid  = drv_valid & sel;
  assign bus2.win_ready = drv_ready;

`ifdef CONWARE_SEQ_STALL_CNT_EN
  logic [31:0] isc4, osc4, isc2, osc2, o_isc, o_osc;
  assign o_isc = sel ? isc2 : isc4;
  assign o_osc = sel ? osc2 : osc4;
`endif

  conware_row_sequencer #(.WIDTH(4), .HEIGHT(4), .GEN_W(16)) dut4 (
    .clk(clk), .rstn(rstn), .enable(en4), .bus(bus4),
    .frame_start(fs4), .frame_done(fd4), .gen_count(gen4), .busy(busy4)
`ifdef CONWARE_SEQ_STALL_CNT_EN
    , .in_stall_cnt(isc4), .out_stall_cnt(osc4)
`endif
  );

  conware_row_sequencer #(.WIDTH(4), .HEIGHT(2), .GEN_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .enable(en2), .bus(bus2),
    .frame_start(fs2), .frame_done(fd2), .gen_count(gen2), .busy(busy2)
`ifdef CONWARE_SEQ_STALL_CNT_EN
    , .in_stall_cnt(isc2), .out_stall_cnt(osc2)
`endif
  );

  logic        o_in_ready, o_win_valid, o_frame_start, o_frame_done, o_busy;
  logic [3:0]  o_top, o_mid, o_bot;
  logic [7:0]  o_row;
  logic [15:0] o_gen;

  assign o_in_ready    = sel ? bus2.in_ready  : bus4.in_ready;
  assign o_win_valid   = sel ? bus2.win_valid : bus4.win_valid;
  assign o_top         = sel ? bus2.win_top   : bus4.win_top;
  assign o_mid         = sel ? bus2.win_mid   : bus4.win_mid;
  assign o_bot         = sel ? bus2.win_bot   : bus4.win_bot;
  assign o_row         = sel ? bus2.win_row   : bus4.win_row;
  assign o_frame_start = sel ? fs2 : fs4;
  assign o_frame_done  = sel ? fd2 : fd4;
  assign o_busy        = sel ? busy2 : busy4;
  assign o_gen         = sel ? {14'd0, gen2} : gen4;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic setCfg(input int in_gap, input bit in_rand, input int out_stall,
                        input bit out_rand, input int out_row, input int drop_win,
                        input int reset_win);
    cfg_in_gap    = in_gap;
    cfg_in_rand   = in_rand;
    cfg_out_stall = out_stall;
    cfg_out_rand  = out_rand;
    cfg_out_row   = out_row;
    cfg_drop_win  = drop_win;
    cfg_reset_win = reset_win;
  endtask

  task automatic randomRows(input int h);
    frame_rows.delete();
    for (int i = 0; i < h; i++) frame_rows.push_back(4'($urandom));
  endtask

  task automatic pulseReset();
    rstn = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(o_busy), 0);
    checkOutput("rst_win_valid", 32'(o_win_valid), 0);
    checkOutput("rst_in_ready", 32'(o_in_ready), 0);
    checkOutput("rst_window", 32'({o_top, o_mid, o_bot, o_row}), 0);
    checkOutput("rst_gen", 32'(o_gen), 0);
    checkOutput("rst_pulses", 32'({o_frame_start, o_frame_done}), 0);
    gen_exp4 = 0;
    gen_exp2 = 0;
    #2 rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs one frame of frame_rows through the selected instance. Called and
  // returning at 1 time unit after a rising edge.
  task automatic applyStimulus(input int h);
    int row_idx = 0, win_idx = 0, gap = 0, stall = 0, cyc = 0;
    int t_row0 = -1, t_row1 = -1, t_first = -1, t_last = -1;
    int starts = 0, overlap_bad = 0, hold_bad = 0, in_st = 0, out_st = 0;
    bit row_x, win_x, new_win = 1, exp_start = 0, exp_done = 0, done = 0, have_hold = 0, en_end = 0;
    logic [3:0] h_top, h_mid, h_bot, e_top, e_bot;
    logic [7:0] h_row;
    drv_en = 1'b1;
    while (cyc < 2000 && !done) begin
      if (o_in_ready && o_win_valid) overlap_bad++;
      if (o_frame_start) starts++;
      if (have_hold && (!o_win_valid || {o_top, o_mid, o_bot, o_row} !== {h_top, h_mid, h_bot, h_row}))
        hold_bad++;
      have_hold = 0;
      if (exp_start) begin
        checkOutput("frame_start", 32'(o_frame_start), 1);
        exp_start = 0;
      end
      if (exp_done) begin
        if (sel) gen_exp2 = (gen_exp2 + 1) % 4;
        else     gen_exp4 = (gen_exp4 + 1) % 65536;
        checkOutput("frame_done", 32'(o_frame_done), 1);
        checkOutput("gen_count", 32'(o_gen), sel ? gen_exp2 : gen_exp4);
        checkOutput("start_pulses", starts, 1);
        checkOutput("handshake_overlap", overlap_bad, 0);
        checkOutput("window_hold", hold_bad, 0);
        checkOutput("first_latency", t_first - t_row1, 1);
        if (cfg_in_gap == 0 && cfg_out_stall == 0)
          checkOutput("frame_cycles", t_last - t_row0, 2 * h - 1);
        checkOutput("busy_after", 32'(o_busy), 32'(en_end));
        checkOutput("in_ready_after", 32'(o_in_ready), 32'(en_end));
`ifdef CONWARE_SEQ_STALL_CNT_EN
        checkOutput("in_stall_cnt", o_isc, in_st);
        checkOutput("out_stall_cnt", o_osc, out_st);
`endif
        done = 1;
      end else begin
        if (o_win_valid && t_first < 0) t_first = cyc;
        if (cfg_reset_win >= 0 && o_win_valid && win_idx == cfg_reset_win) begin
          drv_valid = 1'b0;
          pulseReset();
          return;
        end
        drv_valid = (row_idx < h) && (gap == 0);
        if (drv_valid) drv_data = frame_rows[row_idx];
        else           drv_data = 4'($urandom);
        if (o_in_ready && gap > 0) gap--;
        if (o_win_valid) begin
          if (new_win) begin
            if (cfg_out_row < 0 || cfg_out_row == win_idx)
              stall = cfg_out_rand ? int'($urandom_range(cfg_out_stall, 0)) : cfg_out_stall;
            else
              stall = 0;
            new_win = 0;
          end
          drv_ready = (stall == 0);
          if (stall > 0) stall--;
        end else begin
          drv_ready = 1'($urandom);
        end
        if (o_win_valid && !drv_ready) begin
          have_hold = 1;
          h_top = o_top; h_mid = o_mid; h_bot = o_bot; h_row = o_row;
          out_st++;
        end
        if (o_in_ready && !drv_valid && row_idx > 0) in_st++;
        row_x = o_in_ready && drv_valid;
        win_x = o_win_valid && drv_ready;
        if (win_x) begin
          if (win_idx == 0) e_top = 4'h0;
          else              e_top = frame_rows[win_idx - 1];
          if (win_idx == h - 1) e_bot = 4'h0;
          else                  e_bot = frame_rows[win_idx + 1];
          checkOutput("win_top", 32'(o_top), 32'(e_top));
          checkOutput("win_mid", 32'(o_mid), 32'(frame_rows[win_idx]));
          checkOutput("win_bot", 32'(o_bot), 32'(e_bot));
          checkOutput("win_row", 32'(o_row), win_idx);
          if (win_idx == cfg_drop_win) drv_en = 1'b0;
          if (win_idx == h - 1) begin
            en_end = drv_en;
            t_last = cyc;
          end
        end
        @(posedge clk);
        #1;
        if (row_x) begin
          if (row_idx == 0) begin
            exp_start = 1;
            t_row0 = cyc;
          end
          if (row_idx == 1) t_row1 = cyc;
          row_idx++;
          gap = cfg_in_rand ? int'($urandom_range(cfg_in_gap, 0)) : cfg_in_gap;
        end
        if (win_x) begin
          win_idx++;
          new_win = 1;
          if (win_idx == h) exp_done = 1;
        end
        cyc++;
      end
    end
    if (!done) checkOutput("frame_timeout", 1, 0);
    drv_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; sel = 1'b0; drv_en = 1'b0; drv_valid = 1'b0; drv_ready = 1'b1; drv_data = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(o_busy), 0);
    checkOutput("reset_in_ready", 32'(o_in_ready), 0);
    checkOutput("reset_win_valid", 32'(o_win_valid), 0);
    checkOutput("reset_gen", 32'(o_gen), 0);
    checkOutput("reset_window", 32'({o_top, o_mid, o_bot, o_row}), 0);
    checkOutput("reset_pulses", 32'({o_frame_start, o_frame_done}), 0);
    rstn = 1'b1;
    drv_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_in_ready", 32'(o_in_ready), 0);
    checkOutput("idle_busy", 32'(o_busy), 0);
    drv_valid = 1'b0;

    // Fixed pattern, no stalls.
    frame_rows = '{4'h1, 4'h2, 4'h4, 4'h8};
    setCfg(0, 0, 0, 0, -1, -1, -1);
    applyStimulus(4);
    // Output stalled for 5 cycles on row 1.
    setCfg(0, 0, 5, 0, 1, -1, -1);
    applyStimulus(4);
    // 3-cycle input gaps between rows.
    setCfg(3, 0, 0, 0, -1, -1, -1);
    applyStimulus(4);
    // Enable dropped mid-frame: frame completes, then idle.
    randomRows(4);
    setCfg(0, 0, 0, 0, -1, 1, -1);
    applyStimulus(4);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("dropped_busy", 32'(o_busy), 0);
    checkOutput("dropped_in_ready", 32'(o_in_ready), 0);
    randomRows(4);
    setCfg(0, 0, 0, 0, -1, -1, -1);
    applyStimulus(4);
    // Reset during window r2, then a clean frame.
    randomRows(4);
    setCfg(1, 1, 2, 1, -1, -1, 2);
    applyStimulus(4);
    randomRows(4);
    setCfg(0, 0, 0, 0, -1, -1, -1);
    applyStimulus(4);
    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      randomRows(4);
      setCfg(int'($urandom_range(2, 0)), 1, int'($urandom_range(3, 0)), 1, -1, -1, -1);
      applyStimulus(4);
    end

    // HEIGHT=2 instance: fixed frame, then enough frames to wrap gen_count.
    sel = 1'b1;
    drv_en = 1'b0;
    @(posedge clk);
    #1;
    frame_rows = '{4'hF, 4'h3};
    setCfg(0, 0, 0, 0, -1, -1, -1);
    applyStimulus(2);
    for (int f = 0; f < 4; f++) begin
      randomRows(2);
      setCfg(int'($urandom_range(2, 0)), 1, int'($urandom_range(2, 0)), 1, -1, -1, -1);
      applyStimulus(2);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/conware_row_sequencer.md
Name: conware_row_sequencer

Overview:
- Frame-level controller between the stream-to-row-buffer converter (bit-per-cell rows, valid/ready) and the Conway next-state compute engine.
- Pulls rows one at a time, keeps a 3-row sliding window (above/current/below) and issues one compute command per row with zero padding outside the frame.
- Counts rows and generations, signals frame start/done, and throttles the upstream converter via in_ready.

Parameters:
- WIDTH, 4, cells per row (bits per row word); must match the converter.
- HEIGHT, 4, rows per frame; legal range 2..255.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  run request; sampled only in IDLE and at frame end
- in_data  in  WIDTH  row bits from converter (1 = alive)
- in_valid  in  1  converter holds a complete row
- in_ready  out  1  sequencer accepts row this cycle
- win_top  out  WIDTH  row r-1 (0 when r=0)
- win_mid  out  WIDTH  row r
- win_bot  out  WIDTH  row r+1 (0 when r=HEIGHT-1)
- win_row  out  8  index r of win_mid
- win_valid  out  1  window command valid
- win_ready  in  1  compute engine accepts window
- frame_start  out  1  one-cycle pulse when row 0 is accepted
- frame_done  out  1  one-cycle pulse when the last window is accepted
- gen_count  out  GEN_W  completed frames; wraps modulo 2^GEN_W
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, rstn=0): state=IDLE. prev/cur/nxt row registers=0, row counter=0, gen_count=0. in_ready, win_valid, frame_start, frame_done, busy all 0.
- Transfers: a row transfers when in_valid & in_ready; a window transfers when win_valid & win_ready.
- win_valid and in_ready are decoded from state and are never high in the same cycle.
- Window outputs are driven from registers and are stable while win_valid=1 and win_ready=0.
- IDLE: in_ready=0. If enable=1, go to FILL next cycle.
- FILL: in_ready=1. On a row transfer: cur<=in_data, prev<=0, row counter r<=0, pulse frame_start, go to LOAD.
- LOAD: in_ready=1. On a row transfer: nxt<=in_data, go to EMIT. If in_valid=0, hold (stall).
- EMIT: win_valid=1, top=prev, mid=cur, bot=nxt, win_row=r. On a window transfer: prev<=cur, cur<=nxt, r<=r+1. If the new r equals HEIGHT-1, go to LAST; otherwise go to LOAD.
- LAST: win_valid=1, top=prev, mid=cur, bot=0, win_row=HEIGHT-1. On a window transfer: pulse frame_done, gen_count+1. Then go to FILL if enable=1, else IDLE.
- Minimum latency: row 0 accepted in cycle t, row 1 in t+1, first win_valid in t+2.
- Throughput: 2 cycles per row when nothing stalls.
- enable deasserted mid-frame is ignored; the frame always completes.
- HEIGHT=2: EMIT goes directly to LAST after row 0.
- Reset asserted mid-frame discards all partial state; no frame_done is issued.
- gen_count wraps from all-ones to 0 without a flag.

Optional Feature:
- Macro CONWARE_SEQ_STALL_CNT_EN.
- Defined: adds outputs in_stall_cnt[31:0] and out_stall_cnt[31:0].
  - in_stall_cnt increments each cycle in_ready=1 and in_valid=0.
  - out_stall_cnt increments each cycle win_valid=1 and win_ready=0.
  - Both saturate at all-ones, reset to 0 on rstn, and clear on frame_start.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package conware_pkg holds:
  - state encoding constants: SEQ_IDLE=0, SEQ_FILL=1, SEQ_LOAD=2, SEQ_EMIT=3, SEQ_LAST=4 (3-bit);
  - row-index width constant ROW_W=8;
  - shared default CONWARE_WIDTH=4.
- One sub-module is natural: conware_row_window (prev/cur/nxt registers, shift-on-accept, zero-pad muxing).
- FSM, counters and pulses stay in the top module.

Test Plan:
- Reset then enable=1, HEIGHT=4, rows 0x1,0x2,0x4,0x8 with no stalls, win_ready=1 -> four windows (top,mid,bot): (0,1,2) r0, (1,2,4) r1, (2,4,8) r2, (4,8,0) r3. frame_start at row 0 accept; frame_done with r3; gen_count=1.
- Same frame with win_ready=0 for 5 cycles at r1 -> window held stable, in_ready=0 throughout, no rows lost; out_stall_cnt=5 when the macro is defined.
- in_valid gaps of 3 cycles between rows -> sequencer holds in LOAD. Output sequence identical to scenario 1; in_stall_cnt=9 for 3 gaps.
- enable dropped at r1 -> frame completes (frame_done, gen_count+1), then IDLE with busy=0 and in_ready=0. Re-enable starts a new frame at r0.
- rstn pulsed low during EMIT r2 -> all outputs 0 immediately, gen_count=0. The next enabled frame starts cleanly at r0 with top=0.
- HEIGHT=2, rows 0xF,0x3 -> windows (0,F,3) r0 then (F,3,0) r1. GEN_W=2 looped over 4 frames -> gen_count wraps 3->0.
